// File: rtl/trng_conditioner.sv
// TRNG post-processing: oscillator gating with warm-up, XOR fold, von Neumann
// debiasing, repetition-count health test, byte packing and an output FIFO.
module trng_conditioner #(
  parameter int SIZE      = 8,
  parameter int DEPTH     = 4,
  parameter int WARMUP    = 4,
  parameter int REP_LIMIT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clr_fail,
  input  logic [SIZE-1:0]          raw_in,
  output logic                     ro_en,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     health_fail,
  output logic                     overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(WARMUP + 1);
  localparam int RW = $clog2(REP_LIMIT + 1);

  typedef enum logic {FIRST, SECOND} vn_state_t;

  logic [WW-1:0]   warm_cnt_reg;
  vn_state_t       phase_reg;
  logic            first_reg;
  logic [2:0]      bit_cnt_reg;
  logic [6:0]      acc_reg;
  logic [RW-1:0]   rep_cnt_reg;
  logic [RW-1:0]   rep_cnt_next;
  logic [SIZE-1:0] prev_word_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic [7:0]      mem [DEPTH];

  logic accepted, fold, emit, byte_done, trip, pop, full, push, drop;

  assign accepted  = ro_en && !health_fail && (warm_cnt_reg == WW'(WARMUP));
  assign fold      = ^raw_in;
  assign emit      = accepted && (phase_reg == SECOND) && (first_reg != fold);
  assign byte_done = emit && (bit_cnt_reg == 3'd7);

  // rep_cnt of zero means no previous accepted word since the last restart
  always_comb begin
    rep_cnt_next = rep_cnt_reg;
    if (accepted) begin
      if (rep_cnt_reg == '0 || raw_in != prev_word_reg)
        rep_cnt_next = RW'(1);
      else if (rep_cnt_reg != RW'(REP_LIMIT))
        rep_cnt_next = rep_cnt_reg + RW'(1);
    end
  end

  assign trip = accepted && (rep_cnt_next == RW'(REP_LIMIT));
  assign pop  = out_valid && out_ready;
  assign full = (count_reg == (AW+1)'(DEPTH));
  assign push = byte_done && !trip && (!full || pop);
  assign drop = byte_done && !trip && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ro_en         <= 1'b0;
      health_fail   <= 1'b0;
      overrun       <= 1'b0;
      warm_cnt_reg  <= '0;
      phase_reg     <= FIRST;
      first_reg     <= 1'b0;
      bit_cnt_reg   <= 3'd0;
      acc_reg       <= 7'd0;
      rep_cnt_reg   <= '0;
      prev_word_reg <= '0;
    end else begin
      ro_en       <= enable && !health_fail;
      health_fail <= trip || (health_fail && !clr_fail);
      overrun     <= drop || (overrun && !clr_fail);
      if (!ro_en) begin
        warm_cnt_reg <= '0;
        phase_reg    <= FIRST;
        bit_cnt_reg  <= 3'd0;
        acc_reg      <= 7'd0;
        rep_cnt_reg  <= '0;
      end else begin
        if (warm_cnt_reg != WW'(WARMUP))
          warm_cnt_reg <= warm_cnt_reg + WW'(1);
        rep_cnt_reg <= rep_cnt_next;
        if (accepted)
          prev_word_reg <= raw_in;
        if (trip) begin
          phase_reg   <= FIRST;
          bit_cnt_reg <= 3'd0;
          acc_reg     <= 7'd0;
        end else if (accepted) begin
          if (phase_reg == FIRST) begin
            first_reg <= fold;
            phase_reg <= SECOND;
          end else begin
            phase_reg <= FIRST;
            if (emit) begin
              if (bit_cnt_reg != 3'd7)
                acc_reg[bit_cnt_reg] <= first_reg;
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end
        end
      end
      if (clr_fail)
        rep_cnt_reg <= '0;
    end
  end

  // A health trip flushes the queue so no byte from a suspect source escapes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (trip) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= {first_reg, acc_reg};
  end

  assign out_data   = mem[rd_ptr_reg];
  assign out_valid  = (count_reg != '0);
  assign fill_level = count_reg;

endmodule

// File: tb/tb_trng_conditioner.sv
// Directed bench for trng_conditioner: debias/pack, health trip, FIFO overrun
// and full-with-pop, partial-byte discard and asynchronous reset.
module tb_trng_conditioner;
  localparam int SIZE = 8, DEPTH = 4, WARMUP = 4, REP_LIMIT = 16;

  logic       clk = 1'b0;
  logic       rst, enable, clr_fail, out_ready;
  logic [7:0] raw_in;
  logic       ro_en, out_valid, health_fail, overrun;
  logic [7:0] out_data;
  logic [2:0] fill_level;

  int tests = 0;
  int fails = 0;
  int seen  = 0;

  trng_conditioner #(.SIZE(SIZE), .DEPTH(DEPTH), .WARMUP(WARMUP), .REP_LIMIT(REP_LIMIT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clr_fail(clr_fail), .raw_in(raw_in),
    .ro_en(ro_en), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fill_level(fill_level), .health_fail(health_fail), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] w);
    raw_in = w;
    step();
  endtask

  // bit 1 -> fold pair (1,0); bit 0 -> fold pair (0,1)
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      if (b[i]) begin feed(8'h01); feed(8'h03); end
      else      begin feed(8'h03); feed(8'h01); end
    end
  endtask

  task automatic start();
    enable = 1'b1;
    repeat (1 + WARMUP) step();
  endtask

  task automatic stop();
    enable = 1'b0;
    step();
    step();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clr_fail = 1'b0; out_ready = 1'b0; raw_in = 8'h00;
    step(); step();
    check("rst_ro_en", ro_en, 0);
    check("rst_valid", out_valid, 0);
    check("rst_fill", fill_level, 0);
    check("rst_hf", health_fail, 0);
    check("rst_ovr", overrun, 0);
    rst = 1'b0;
    step();

    // single 0xA5 byte with the consumer always ready
    out_ready = 1'b1;
    start();
    check("warm_ro_en", ro_en, 1);
    send_bits(8'hA5, 7);
    feed(8'h01);
    check("a5_valid_early", out_valid, 0);
    feed(8'h03);
    check("a5_valid", out_valid, 1);
    check("a5_data", out_data, 8'hA5);
    check("a5_fill", fill_level, 1);
    feed(8'h05);
    check("a5_popped", out_valid, 0);
    stop();

    // equal fold pairs never emit
    start();
    for (int i = 0; i < 16; i++) begin
      feed(8'h03); if (out_valid) seen++;
      feed(8'h05); if (out_valid) seen++;
      feed(8'h01); if (out_valid) seen++;
      feed(8'h02); if (out_valid) seen++;
    end
    check("eq_no_bytes", seen, 0);
    check("eq_fill", fill_level, 0);
    check("eq_hf", health_fail, 0);
    stop();

    // repetition trip with two bytes queued
    out_ready = 1'b0;
    start();
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    check("rep_fill_pre", fill_level, 2);
    repeat (REP_LIMIT - 1) feed(8'h5A);
    check("rep_hf_early", health_fail, 0);
    feed(8'h5A);
    check("rep_hf", health_fail, 1);
    check("rep_flush", fill_level, 0);
    check("rep_ro_en_still", ro_en, 1);
    step();
    check("rep_ro_en_drop", ro_en, 0);
    clr_fail = 1'b1;
    step();
    clr_fail = 1'b0;
    check("clr_hf", health_fail, 0);
    step();
    check("clr_ro_en", ro_en, 1);
    feed(8'h01); feed(8'h03); feed(8'h01); feed(8'h03);
    send_bits(8'hA5, 8);
    check("clr_warm_fill", fill_level, 1);
    check("clr_warm_data", out_data, 8'hA5);
    stop();
    out_ready = 1'b1;
    step();
    check("clr_drain", fill_level, 0);
    out_ready = 1'b0;

    // overrun: five bytes into a four-deep FIFO
    start();
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    send_bits(8'h33, 8);
    send_bits(8'h44, 8);
    check("ovr_fill4", fill_level, 4);
    check("ovr_clear", overrun, 0);
    send_bits(8'h55, 8);
    check("ovr_fill", fill_level, 4);
    check("ovr_flag", overrun, 1);
    stop();
    check("ovr_hold", out_data, 8'h11);
    out_ready = 1'b1;
    check("ovr_rd0", out_data, 8'h11); step();
    check("ovr_rd1", out_data, 8'h22); step();
    check("ovr_rd2", out_data, 8'h33); step();
    check("ovr_rd3", out_data, 8'h44); step();
    check("ovr_empty", out_valid, 0);
    out_ready = 1'b0;
    clr_fail = 1'b1;
    step();
    clr_fail = 1'b0;
    check("ovr_cleared", overrun, 0);

    // full FIFO, byte completes in the same cycle as a pop
    start();
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    send_bits(8'h33, 8);
    send_bits(8'h44, 8);
    send_bits(8'h55, 7);
    feed(8'h03);
    out_ready = 1'b1;
    feed(8'h01);
    out_ready = 1'b0;
    check("fp_fill", fill_level, 4);
    check("fp_ovr", overrun, 0);
    stop();
    out_ready = 1'b1;
    check("fp_rd0", out_data, 8'h22); step();
    check("fp_rd1", out_data, 8'h33); step();
    check("fp_rd2", out_data, 8'h44); step();
    check("fp_rd3", out_data, 8'h55); step();
    check("fp_empty", fill_level, 0);
    out_ready = 1'b0;

    // partial byte discarded on disable
    start();
    send_bits(8'hFF, 5);
    stop();
    start();
    send_bits(8'hA5, 8);
    check("part_fill", fill_level, 1);
    check("part_data", out_data, 8'hA5);

    // asynchronous reset mid-byte
    send_bits(8'h0F, 3);
    rst = 1'b1;
    #1;
    check("arst_ro_en", ro_en, 0);
    check("arst_valid", out_valid, 0);
    check("arst_fill", fill_level, 0);
    check("arst_hf", health_fail, 0);
    #2;
    rst = 1'b0;
    step();
    check("arst_fill_after", fill_level, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
